// File: rtl/booth_divider.sv
// booth_divider: sequential signed restoring divider, one quotient bit per clock.
// Accepts a DVD_W-bit signed dividend (Booth product format) and a DVS_W-bit
// signed divisor; returns a saturating truncated quotient and a remainder whose
// sign follows the dividend, with fixed latency and a one-cycle done pulse.
module booth_divider #(
  parameter int DVD_W = 15,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             St,
  input  logic [DVD_W-1:0] Dividend,
  input  logic [DVS_W-1:0] Divisor,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dz
);

  localparam int               CNT_W     = $clog2(DVD_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DVD_W - 1);
  localparam logic [DVD_W-1:0] Q_POS_MAX = DVD_W'((1 << (DVS_W - 1)) - 1);
  localparam logic [DVD_W-1:0] Q_NEG_MAX = DVD_W'(1 << (DVS_W - 1));
  localparam logic [DVS_W-1:0] SAT_POS   = {1'b0, {(DVS_W-1){1'b1}}};
  localparam logic [DVS_W-1:0] SAT_NEG   = {1'b1, {(DVS_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [DVS_W:0]   r_rem;      // partial remainder, DVS_W+1 bits wide
  logic [DVS_W-1:0] r_dvs_mag;  // |Divisor|; -2^(DVS_W-1) maps to 2^(DVS_W-1) unsigned
  logic             r_sd;
  logic             r_sv;
  logic             r_zd;
  logic [DVS_W-1:0] r_quotient;
  logic [DVS_W-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             r_dz;

  logic [DVD_W-1:0] w_dvd_mag;
  logic [DVS_W-1:0] w_dvs_mag;
  logic [DVS_W+1:0] w_r_sh;
  logic [DVS_W+1:0] w_trial;
  logic             w_trial_ok;
  logic [DVS_W-1:0] w_q_fix;
  logic [DVS_W-1:0] w_r_fix;
  logic             w_ovf_fix;

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

  // One restoring step: shift {R,Q} left and try subtracting |Divisor|.
  assign w_r_sh     = {r_rem, r_quo[DVD_W-1]};
  assign w_trial    = w_r_sh - {2'b00, r_dvs_mag};
  assign w_trial_ok = ~w_trial[DVS_W+1];

  // Operand magnitudes taken from the live inputs at the accepting edge.
  always_comb begin
    w_dvd_mag = Dividend;
    w_dvs_mag = Divisor;
    if (Dividend[DVD_W-1]) begin
      w_dvd_mag = ~Dividend + DVD_W'(1);
    end else begin
      w_dvd_mag = Dividend;
    end
    if (Divisor[DVS_W-1]) begin
      w_dvs_mag = ~Divisor + DVS_W'(1);
    end else begin
      w_dvs_mag = Divisor;
    end
  end

  // Sign application, saturation and divide-by-zero results loaded in FIX.
  always_comb begin
    w_q_fix   = {DVS_W{1'b0}};
    w_r_fix   = {DVS_W{1'b0}};
    w_ovf_fix = 1'b0;
    if (r_zd) begin
      w_q_fix   = {DVS_W{1'b0}};
      w_r_fix   = {DVS_W{1'b0}};
      w_ovf_fix = 1'b0;
    end else begin
      if (r_sd ^ r_sv) begin
        if (r_quo > Q_NEG_MAX) begin
          w_q_fix   = SAT_NEG;
          w_ovf_fix = 1'b1;
        end else begin
          w_q_fix   = ~r_quo[DVS_W-1:0] + DVS_W'(1);
          w_ovf_fix = 1'b0;
        end
      end else begin
        if (r_quo > Q_POS_MAX) begin
          w_q_fix   = SAT_POS;
          w_ovf_fix = 1'b1;
        end else begin
          w_q_fix   = r_quo[DVS_W-1:0];
          w_ovf_fix = 1'b0;
        end
      end
      // Remainder magnitude is always below |Divisor| so its low DVS_W bits suffice.
      if (r_sd) begin
        w_r_fix = ~r_rem[DVS_W-1:0] + DVS_W'(1);
      end else begin
        w_r_fix = r_rem[DVS_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (St) begin
          w_next = S_CALC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_next = S_FIX;
        end else begin
          w_next = S_CALC;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and output registers: capture, iterate, then publish results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= {CNT_W{1'b0}};
      r_quo       <= {DVD_W{1'b0}};
      r_rem       <= {(DVS_W+1){1'b0}};
      r_dvs_mag   <= {DVS_W{1'b0}};
      r_sd        <= 1'b0;
      r_sv        <= 1'b0;
      r_zd        <= 1'b0;
      r_quotient  <= {DVS_W{1'b0}};
      r_remainder <= {DVS_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (St) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_quo     <= w_dvd_mag;
            r_rem     <= {(DVS_W+1){1'b0}};
            r_dvs_mag <= w_dvs_mag;
            r_sd      <= Dividend[DVD_W-1];
            r_sv      <= Divisor[DVS_W-1];
            r_zd      <= (Divisor == {DVS_W{1'b0}});
            r_busy    <= 1'b1;
          end
        end
        S_CALC: begin
          if (w_trial_ok) begin
            r_rem <= w_trial[DVS_W:0];
          end else begin
            r_rem <= w_r_sh[DVS_W:0];
          end
          r_quo <= {r_quo[DVD_W-2:0], w_trial_ok};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_quotient  <= w_q_fix;
          r_remainder <= w_r_fix;
          r_ovf       <= w_ovf_fix;
          r_dz        <= r_zd;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: scoreboard bench for booth_divider. Stimulus pushes the
// expected result (from plain integer division) and its due cycle; a monitor
// pops and compares whenever done is seen.
module tb_booth_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        St;
  logic [14:0] Dividend;
  logic [7:0]  Divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        dz;

  booth_divider dut (
    .clk(clk), .rst(rst), .St(St), .Dividend(Dividend), .Divisor(Divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  // Free-running cycle count used for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: truncating integer division, saturation to the 8-bit range.
  function automatic exp_t model(int dvd, int dvs, int due);
    exp_t e;
    int qi;
    int ri;
    e.due = due;
    if (dvs == 0) begin
      e.q = 8'd0; e.r = 8'd0; e.ovf = 1'b0; e.dz = 1'b1;
    end else begin
      qi = dvd / dvs;
      ri = dvd % dvs;
      e.dz = 1'b0;
      e.r  = 8'(ri);
      if (qi > 127) begin
        e.q = 8'h7F; e.ovf = 1'b1;
      end else if (qi < -128) begin
        e.q = 8'h80; e.ovf = 1'b1;
      end else begin
        e.q = 8'(qi); e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_has_pending", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("dz", int'(dz), int'(e.dz));
        chk("latency_cycle", cyc, e.due);
      end
    end
  end

  // One division; returns so the next call is accepted back-to-back.
  task automatic issue(int dvd, int dvs);
    @(negedge clk);
    St = 1'b1;
    Dividend = 15'(dvd);
    Divisor  = 8'(dvs);
    sb.push_back(model(dvd, dvs, cyc + 17));
    @(negedge clk);
    St = 1'b0;
    Dividend = 15'($urandom);
    Divisor  = 8'($urandom);
    chk("busy_after_accept", int'(busy), 1);
    repeat (15) @(negedge clk);
  endtask

  initial begin
    int a;
    int b;
    int n0;
    rst = 1'b1; St = 1'b0; Dividend = 15'd0; Divisor = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_quotient", int'(quotient), 0);
    chk("reset_remainder", int'(remainder), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_dz", int'(dz), 0);
    rst = 1'b0;

    issue(100, 7);
    issue(-100, 7);
    issue(100, -7);
    issue(-16256, -128);
    issue(-16384, -128);
    issue(500, 0);
    issue(-16384, 1);
    issue(16383, -1);

    // St held high across two runs: second accepted in the done cycle.
    @(negedge clk);
    n0 = cyc;
    St = 1'b1; Dividend = 15'd100; Divisor = 8'd7;
    sb.push_back(model(100, 7, n0 + 17));
    @(negedge clk);
    Dividend = 15'(-1000); Divisor = 8'd8;
    sb.push_back(model(-1000, 8, n0 + 34));
    repeat (17) @(negedge clk);
    St = 1'b0;
    repeat (16) @(negedge clk);

    // Reset at iteration 8 aborts silently; outputs cleared.
    @(negedge clk);
    St = 1'b1; Dividend = 15'd1234; Divisor = 8'(-9);
    @(negedge clk);
    St = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_dz", int'(dz), 0);
    repeat (20) @(negedge clk);
    issue(-1000, 8);

    // Multiplier products fed back: quotient must recover the multiplicand.
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(255)) - 128;
      b = 0;
      while (b == 0) b = int'($urandom_range(255)) - 128;
      if (a == -128 && b == -128) a = -127;
      issue(a * b, b);
    end

    // Arbitrary operands, covering overflow and occasional zero divisors.
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(32767)) - 16384;
      b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(255)) - 128;
      issue(a, b);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", int'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed divider, the inverse datapath of the team's 8-bit Booth multiplier. It accepts a 15-bit signed dividend in the multiplier's product format and an 8-bit signed divisor, and iterates one restoring-division step per clock. It returns an 8-bit signed quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic unit, so a product can be fed back and checked against its multiplicand.

## Interface
- DVD_W, 15: dividend width (two's complement). Only the default is verified.
- DVS_W, 8: divisor, quotient and remainder width (two's complement). Only the default is verified.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- St  in  1  start; sampled only in IDLE.
- Dividend  in  DVD_W  signed dividend; captured on the accepting edge.
- Divisor  in  DVS_W  signed divisor; captured on the accepting edge.
- quotient  out  DVS_W  signed quotient, truncated toward zero, registered.
- remainder  out  DVS_W  signed remainder, registered; its sign follows the dividend.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse when the result registers update.
- ovf  out  1  quotient overflow flag; valid with done, held until the next done.
- dz  out  1  divide-by-zero flag; valid with done, held until the next done.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with St=1: capture the following, then go to CALC with the iteration counter at 0:
  - |Dividend| as a DVD_W-bit unsigned value;
  - |Divisor| as a DVS_W-bit unsigned value (-128 gives 128);
  - sign of the dividend, sign of the divisor, and a zero-divisor flag.
- IDLE with St=0 stays in IDLE.
- CALC runs one restoring step per clock:
  - shift {R, Q} left by 1;
  - compute trial = R - |Divisor|, with R sized DVS_W+1 bits;
  - if trial is non-negative, R = trial and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
- CALC runs exactly DVD_W iterations, then goes to FIX.
- FIX (one cycle) applies the signs:
  - quotient sign = sign(dividend) XOR sign(divisor);
  - remainder sign = sign(dividend);
  - FIX then loads the output registers, pulses done, and returns to IDLE.
- Overflow handling:
  - if the signed quotient is outside [-2^(DVS_W-1), 2^(DVS_W-1)-1], set ovf=1;
  - quotient saturates to 127 (positive) or -128 (negative);
  - remainder is still the true remainder.
- Divide by zero: the full latency still elapses; dz=1, ovf=0, quotient=0, remainder=0.
- The remainder magnitude is always below |Divisor| ≤ 128, so it always fits DVS_W bits.
- St while busy=1 is ignored; no queueing.
- Dividend and Divisor are don't-care except on the accepting edge.

## Timing
- Reset: on any edge with rst=1:
  - state goes to IDLE;
  - quotient, remainder, busy, done, ovf and dz all go to 0;
  - counter and working registers are cleared.
- rst has priority over St. Reset mid-operation aborts with no done pulse.
- Edge E0 (IDLE, St=1) sets busy=1.
- Edges E1..E15 perform the CALC iterations.
- Edge E16 (FIX) updates outputs, sets done=1 and busy=0.
- Latency is 16 clocks from the accepting edge to done high, fixed for every operand, including dz and ovf cases.
- done is high for exactly one cycle, the cycle after E16.
- The FSM is in IDLE during the done cycle, so St=1 there is accepted at E17 (back-to-back throughput of 17 cycles).
- quotient, remainder, ovf and dz change only at a FIX edge or reset, and hold between divisions.

## Test plan
- Positive operands: Dividend=100, Divisor=7, St pulse → done 16 clocks later with quotient=14 (8'h0E), remainder=2, ovf=0, dz=0.
- Negative dividend: Dividend=-100, Divisor=7 → quotient=-14 (8'hF2), remainder=-2 (8'hFE).
- Negative divisor: Dividend=100, Divisor=-7 → quotient=-14, remainder=2.
- Both negative: Dividend=-16256, Divisor=-128 → quotient=127, remainder=0, ovf=0.
- Overflow: Dividend=-16384, Divisor=-128 → ovf=1, quotient=127 (8'h7F), remainder=0.
- Divide by zero: Dividend=500, Divisor=0 → dz=1, quotient=0, remainder=0, done still at 16 clocks.
- St held high throughout a run → second result (e.g. -1000/8 → quotient=-125 (8'h83), remainder=0) with done 17 cycles after the first.
- Reset mid-run: assert rst at iteration 8 → all outputs 0, no done pulse; the next St runs normally.
- Self-check: feed random Booth-multiplier products (a×b) with divisor b≠0 → quotient=a, remainder=0.
